latch_bank_wr_seq: RTL
======================

// Module: latch_bank_wr_seq
// PURPOSE
//   Write sequencer for a bank of transparent, active-high-enable latches. Drives shared D and
//   one-hot E. Takes a valid/ready write request and produces timed phases for the latch bank:
//   setup (D stable, E low), pulse (E high) and hold (E low, D held). Sits between the
//   synchronous register-file logic and the latch-array storage column.
// PARAMETERS
//   DW        8  data width, one bit per latch in a row
//   AW        3  address width
//   DEPTH     8  number of latch rows; must be <= 2**AW
//   SETUP_CYC 1  cycles D is driven before E rises; must be >= 1
//   PULSE_CYC 2  cycles E is high; must be >= 1
//   HOLD_CYC  1  cycles D is held after E falls; must be >= 1
// PORTS
//   CLK       in   1      clock; all state changes on the rising edge
//   RST       in   1      synchronous reset, active high
//   WR_VALID  in   1      write request valid
//   WR_READY  out  1      sequencer idle; request accepted when WR_VALID & WR_READY
//   WR_ADDR   in   AW     target row
//   WR_DATA   in   DW     write data
//   LAT_E     out  DEPTH  one-hot latch enables (registered, glitch-free)
//   LAT_D     out  DW(+1) latch data bus (registered); +1 parity bit only with LATCH_WR_PARITY_EN
//   BUSY      out  1      high in SETUP, PULSE and HOLD
//   WR_DONE   out  1      1-cycle pulse after HOLD completes
//   ERR_ADDR  out  1      1-cycle pulse with WR_DONE when the accepted WR_ADDR >= DEPTH
// BEHAVIOUR
//   Reset, sampled at an edge: state=IDLE, LAT_E=0, LAT_D=0, WR_DONE=0, ERR_ADDR=0, BUSY=0,
//     counter=0. WR_READY=0 while RST is high and 1 in IDLE afterwards.
//   FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE. One down-counter is loaded on each phase entry.
//   IDLE: WR_READY=1. On accept, capture WR_ADDR and WR_DATA, then go to SETUP.
//     LAT_D holds its last value in IDLE. It never changes except when a write is accepted.
//   SETUP (SETUP_CYC cycles): LAT_D=captured data. LAT_E=0.
//   PULSE (PULSE_CYC cycles): LAT_E[addr]=1 and all other bits 0. LAT_D unchanged.
//     For an out-of-range address, LAT_E stays 0 and the phases still run.
//   HOLD (HOLD_CYC cycles): LAT_E=0. LAT_D unchanged.
//   On leaving HOLD: WR_DONE=1 (and ERR_ADDR if out of range) for exactly the first IDLE cycle.
//     WR_READY is also 1 in that cycle.
//   Latency: accept at edge t. LAT_D valid in cycle t+1.
//     LAT_E high in cycles t+1+SETUP_CYC .. t+SETUP_CYC+PULSE_CYC.
//     WR_DONE in cycle t+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
//     Throughput: 1 write per 1+SETUP+PULSE+HOLD cycles (5 with defaults).
//   WR_VALID while busy is ignored: no capture, no queueing. Requester must hold it until ready.
//   A request may be accepted in the same cycle WR_DONE is high (back-to-back).
//   LAT_E and LAT_D never change on the same edge. D must not toggle while any E is high.
//   Reset mid-operation: LAT_E drops to 0 at the reset edge and the write is abandoned.
//     Row content is undefined. No WR_DONE pulse is produced.
//   Parameter violation (DEPTH > 2**AW, or any *_CYC < 1): elaboration-time $error.
// CONFIGURATION
//   LATCH_WR_PARITY_EN defined: LAT_D is DW+1 bits wide.
//     LAT_D[DW] = ^WR_DATA (even parity), captured and timed with the data.
//     Reset value is 0.
//   LATCH_WR_PARITY_EN undefined: LAT_D is DW bits wide and no parity logic exists.
// TESTING
//   1 Reset then idle: RST=1 for 2 cycles -> LAT_E=0, LAT_D=0, WR_READY=0; after RST=0 -> WR_READY=1, BUSY=0.
//   2 Single write addr=5 data=8'hA5, defaults -> LAT_D=A5 from t+1.
//     LAT_E=8'h20 in cycles t+2..t+3. WR_DONE in cycle t+5. LAT_D still A5 in t+5.
//   3 Back-to-back: addr 0/3C, then addr 7/C3 offered while WR_DONE=1 -> second accepted at once.
//     LAT_E=01 then 80. No overlap. D changes only while LAT_E=0.
//   4 Out of range: DEPTH=6, addr=6 -> LAT_E stays 0 for the whole write. WR_DONE and ERR_ADDR pulse together.
//   5 RST asserted in the 2nd PULSE cycle -> LAT_E=0 and LAT_D=0 at that edge. No WR_DONE. WR_READY=1 after release.
//   6 With LATCH_WR_PARITY_EN: data=8'h07 -> LAT_D=9'h107; data=8'h03 -> LAT_D=9'h003.

Source files
------------

// File: rtl/latch_bank_wr_seq.sv
// Write sequencer for a transparent-latch bank: it times setup, enable-pulse and hold phases on D/E.
// Optional feature macro LATCH_WR_PARITY_EN: adds an even-parity bit as LAT_D[DW].
module latch_bank_wr_seq #(
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int DEPTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
`ifdef LATCH_WR_PARITY_EN
    localparam int LDW = DW + 1
`else
    localparam int LDW = DW
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [DW-1:0]    WR_DATA,
    output logic [DEPTH-1:0] LAT_E,
    output logic [LDW-1:0]   LAT_D,
    output logic             BUSY,
    output logic             WR_DONE,
    output logic             ERR_ADDR
);

    localparam int MAXC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAXC_A > HOLD_CYC) ? MAXC_A : HOLD_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    generate
        if (DEPTH > 2**AW) begin : g_bad_depth
            $error("latch_bank_wr_seq: DEPTH exceeds 2**AW");
        end
        if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
            $error("latch_bank_wr_seq: SETUP_CYC, PULSE_CYC and HOLD_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DEPTH-1:0] lat_e_q, lat_e_d;
    logic [LDW-1:0]   lat_d_q, lat_d_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [LDW-1:0]   cap_data;
    logic [DEPTH-1:0] row_sel;
    logic             addr_oor;
    logic             accept;

`ifdef LATCH_WR_PARITY_EN
    assign cap_data = {^WR_DATA, WR_DATA};
`else
    assign cap_data = WR_DATA;
`endif

    // Out-of-range addresses match no row, so the enable pulse stays all-zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_sel
            assign row_sel[gi] = (addr_q == AW'(gi));
        end
    endgenerate

    assign addr_oor = ({1'b0, addr_q} >= DEPTH_LIM);
    assign WR_READY = (state_q == S_IDLE) && !RST;
    assign accept   = WR_VALID && WR_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lat_e_d = lat_e_q;
        lat_d_d = lat_d_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                lat_e_d = '0;
                if (accept) begin
                    addr_d  = WR_ADDR;
                    lat_d_d = cap_data;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    lat_e_d = row_sel;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    lat_e_d = '0;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    err_d   = addr_oor;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                lat_e_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_e_q <= '0;
            lat_d_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lat_e_q <= lat_e_d;
            lat_d_q <= lat_d_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign LAT_E    = lat_e_q;
    assign LAT_D    = lat_d_q;
    assign BUSY     = (state_q != S_IDLE);
    assign WR_DONE  = done_q;
    assign ERR_ADDR = err_q;

endmodule
